// File: rtl/multi_enq_pkg.sv
// Shared types and helpers for the multi-element enqueue compactor.
package multi_enq_pkg;

    localparam int N            = 4;
    localparam int MAX_CAPACITY = 16;
    localparam int CNT_BITS     = $clog2(N + 1);
    localparam int CAPACITYBITS = $clog2(MAX_CAPACITY + 1);
    localparam int IDX_W        = (N > 1) ? $clog2(N) : 1;

    typedef logic [7:0]              elem_t;
    typedef logic [CNT_BITS-1:0]     count_t;
    typedef logic [CAPACITYBITS:0]   free_t;

    function automatic count_t popcount(input logic [N-1:0] m);
        count_t c;
        c = '0;
        for (int i = 0; i < N; i++) begin
            c = c + count_t'(m[i]);
        end
        return c;
    endfunction

    function automatic count_t min_count(input count_t a, input free_t b);
        if (b < free_t'(a)) begin
            return count_t'(b);
        end
        return a;
    endfunction

endpackage

// File: rtl/lane_compactor.sv
// Combinational prefix-sum compaction: packs masked lanes densely, lane order preserved.
module lane_compactor
    import multi_enq_pkg::*;
(
    input  logic [N-1:0]  mask,
    input  elem_t [N-1:0] data,
    output elem_t [N-1:0] compact_data,
    output count_t        count
);

    count_t slot;

    always_comb begin
        slot         = '0;
        compact_data = '0;
        for (int i = 0; i < N; i++) begin
            if (mask[i]) begin
                compact_data[slot[IDX_W-1:0]] = data[i];
                slot = slot + count_t'(1);
            end
        end
    end

    assign count = popcount(mask);

endmodule

// File: rtl/multi_enq_compactor.sv
// Compacts N-lane masked beats and feeds them to a multi-enqueue FIFO within its free space.
// Optional counters are enabled with MULTI_ENQ_COMPACTOR_STATS_EN.
module multi_enq_compactor
    import multi_enq_pkg::*;
(
    input  logic                    clk,
    input  logic                    rstn,
    input  logic                    flush,
    input  logic                    in_valid,
    input  logic [N-1:0]            in_mask,
    input  elem_t [N-1:0]           in_data,
    output logic                    in_ready,
    input  logic [CAPACITYBITS-1:0] fifo_fill_level,
    output count_t                  enq_count,
    output elem_t [N-1:0]           enq_data
`ifdef MULTI_ENQ_COMPACTOR_STATS_EN
    ,
    output logic [31:0]             stat_stall_cycles,
    output logic [31:0]             stat_elems
`endif
);

    count_t        pend_cnt;
    elem_t [N-1:0] pend_data;
    elem_t [N-1:0] cmp_data;
    elem_t [N-1:0] shifted;
    count_t        cmp_cnt;
    free_t         free;
    logic          accept;
    int            src;

    lane_compactor u_lane_compactor (
        .mask         (in_mask),
        .data         (in_data),
        .compact_data (cmp_data),
        .count        (cmp_cnt)
    );

    // Clamp so an over-reported fill level reads as a full FIFO, never wraps.
    assign free = (free_t'(fifo_fill_level) >= free_t'(MAX_CAPACITY)) ? '0
                : free_t'(MAX_CAPACITY) - free_t'(fifo_fill_level);

    assign enq_count = flush ? '0 : min_count(pend_cnt, free);
    assign enq_data  = pend_data;
    assign in_ready  = !flush && (enq_count == pend_cnt);
    assign accept    = in_valid && in_ready;

    always_comb begin
        shifted = pend_data;
        src     = 0;
        for (int i = 0; i < N; i++) begin
            src = i + int'(enq_count);
            if (src < N) begin
                shifted[i] = pend_data[src[IDX_W-1:0]];
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            pend_cnt <= '0;
        end else if (flush) begin
            pend_cnt <= '0;
        end else if (accept) begin
            pend_cnt <= cmp_cnt;
        end else begin
            pend_cnt <= pend_cnt - enq_count;
        end
    end

    // Data needs no reset: pend_cnt alone qualifies it.
    always_ff @(posedge clk) begin
        if (accept) begin
            pend_data <= cmp_data;
        end else begin
            pend_data <= shifted;
        end
    end

`ifdef MULTI_ENQ_COMPACTOR_STATS_EN
    logic [32:0] elem_sum;

    assign elem_sum = {1'b0, stat_elems} + 33'(enq_count);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            stat_stall_cycles <= '0;
            stat_elems        <= '0;
        end else begin
            if (in_valid && !in_ready && (stat_stall_cycles != '1)) begin
                stat_stall_cycles <= stat_stall_cycles + 32'd1;
            end
            stat_elems <= elem_sum[32] ? '1 : elem_sum[31:0];
        end
    end
`endif

endmodule

// File: doc/multi_enq_compactor.md
Name: multi_enq_compactor

Overview:
- Producer-side stage placed directly upstream of the multi-element enqueue/dequeue FIFO.
- Accepts a ready/valid beat of N lanes, each with its own per-lane valid bit.
- Compacts the valid lanes into a dense, order-preserving group held in a pending register.
- Drives the FIFO's enqueue count and data, never exceeding the free space derived from the FIFO's fill level. Backpressures the producer while elements remain pending.

Parameters:
- T, logic [7:0], element type.
- N, 4, lanes per beat; also the FIFO's max enqueue per cycle.
- MAX_CAPACITY, 16, capacity of the downstream FIFO.
- CNT_BITS, $clog2(N+1), width of per-cycle element counts.
- CAPACITYBITS, $clog2(MAX_CAPACITY+1), width of the fill level.

Ports:
- clk  in  1  clock.
- rstn  in  1  asynchronous active-low reset.
- flush  in  1  synchronous discard of pending elements.
- in_valid  in  1  producer beat valid.
- in_mask  in  N  per-lane valid; bit i qualifies in_data[i].
- in_data  in  N x T  lane data.
- in_ready  out  1  beat accepted when in_valid && in_ready.
- fifo_fill_level  in  CAPACITYBITS  downstream FIFO occupancy (registered in the FIFO).
- enq_count  out  CNT_BITS  elements enqueued this cycle; connects to the FIFO's valid_in.
- enq_data  out  N x T  compacted elements; entries 0..enq_count-1 are meaningful.

Behaviour:
- Reset/clocking: rstn asynchronous, active-low; clock clk. All state updates on posedge clk.
- Reset values: pend_cnt=0; pend_data don't-care. Combinationally this gives enq_count=0 and in_ready=1.
- State: pend_cnt (0..N) and pend_data[N] (compacted, oldest at index 0). Two states, derived from pend_cnt:
  - EMPTY: pend_cnt==0.
  - HOLD: pend_cnt>0.
- Free space: free = MAX_CAPACITY - fifo_fill_level, computed at CAPACITYBITS+1 width with no wrap.
- Enqueue count: enq_count = min(pend_cnt, free). It is combinational and never exceeds N. enq_data = pend_data.
- Ready: in_ready = !flush && (enq_count == pend_cnt), i.e. the pending group fully drains this cycle. Combinational path from fifo_fill_level to in_ready is permitted.
- Accept (in_valid && in_ready):
  - Compact in_mask lanes in ascending lane order.
  - pend_data <= compacted; pend_cnt <= popcount(in_mask).
  - Latency: lane data appears on enq_data the next cycle (1 cycle) when free space allows.
- Partial drain (enq_count < pend_cnt, no accept):
  - pend_data shifts down by enq_count, preserving order.
  - pend_cnt <= pend_cnt - enq_count.
  - in_ready stays 0.
- Full drain with no new beat: pend_cnt <= 0.
- in_mask all-zero beat: accepted, pend_cnt <= 0, no enqueue. Counts as a handshake.
- FIFO full (free==0): enq_count=0; pending held; in_ready=0 if pend_cnt>0, otherwise 1.
- Wrap/fill consistency: the FIFO updates fill_level on the same edge as the enqueue, so the next-cycle free value is already correct. No local credit tracking.
- flush:
  - Highest priority.
  - enq_count forced to 0 and in_ready=0 that cycle.
  - pend_cnt <= 0 at the edge; the producer beat is not accepted.
- Reset mid-operation: pending elements are lost. The consumer FIFO is reset by the same rstn.
- Invariants:
  - enq_count <= free.
  - enq_count <= N.
  - Never enqueue in the same cycle as flush.

Optional Feature:
- Macro: MULTI_ENQ_COMPACTOR_STATS_EN.
- Defined:
  - Adds output stat_stall_cycles [31:0]: counts cycles with in_valid && !in_ready.
  - Adds output stat_elems [31:0]: sums enq_count.
  - Both counters saturate at all-ones and reset to 0 on rstn; flush does not clear them.
- Undefined: neither port nor counter exists; behaviour is otherwise identical.

Decomposition:
- Package multi_enq_pkg:
  - count_t typedef (CNT_BITS).
  - popcount function.
  - min_count function.
- Sub-module lane_compactor: purely combinational prefix-sum compaction. Inputs mask[N] and data[N]; outputs packed[N] and count. Instantiated once on the input path.
- Partial-drain shifter stays inline in the top module.

Test Plan:
- Reset, then mask=4'b1111 with data A,B,C,D, fill=0 -> next cycle enq_count=4, enq_data=A,B,C,D; in_ready=1 throughout.
- Mask=4'b1010 with data w,x,y,z, fill=0 -> next cycle enq_count=2, enq_data[0]=x, enq_data[1]=z.
- Pending 4 elements, fill=14 (free=2) -> enq_count=2 and in_ready=0. Next cycle with fill=16: enq_count=0 and pend_cnt=2. Then fill=13: enq_count=2 with the remaining elements in order, and in_ready=1.
- Back-to-back full beats for 8 cycles with fill held low -> enq_count=4 every cycle after the first, no stall, order preserved.
- Pending 3 elements, free=0, flush=1 -> enq_count=0 and in_ready=0 that cycle. Next cycle pend_cnt=0 and in_ready=1; the flushed elements never appear.
- Mask=0 beat accepted -> enq_count=0 next cycle. With STATS_EN, 5 stalled cycles -> stat_stall_cycles=5.
